// File: rtl/comp_pkg.sv
// Op-code definitions and the shared next-value/carry function for the
// general-purpose register bank.
package comp_pkg;

    // Widest register the op function supports; narrower values are
    // zero-extended into this width and masked back down.
    localparam int MAX_W = 64;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_DEC = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SHR = 3'b100;
    localparam logic [2:0] OP_CLR = 3'b101;
    localparam logic [2:0] OP_CPL = 3'b110;

    typedef struct packed {
        logic [MAX_W-1:0] val;  // next register value (upper bits zero)
        logic             c;    // carry / shift-out produced by the op
        logic             cv;   // op is one that updates carry
    } op_res_t;

    // Compute next value and carry for a w-bit register holding v.
    function automatic op_res_t op_apply(input logic [2:0] op,
                                         input logic [MAX_W-1:0] v,
                                         input int w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] msb;
        op_res_t          r;
        mask  = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        msb   = mask ^ (mask >> 1);
        r.val = v;
        r.c   = 1'b0;
        r.cv  = 1'b0;
        case (op)
            OP_INC: begin
                r.val = (v + MAX_W'(1)) & mask;
                r.c   = (v == mask);
                r.cv  = 1'b1;
            end
            OP_DEC: begin
                r.val = (v - MAX_W'(1)) & mask;
                r.c   = (v == '0);
                r.cv  = 1'b1;
            end
            OP_SHL: begin
                r.val = (v << 1) & mask;
                r.c   = |(v & msb);
                r.cv  = 1'b1;
            end
            OP_SHR: begin
                r.val = v >> 1;
                r.c   = v[0];
                r.cv  = 1'b1;
            end
            OP_CLR: r.val = '0;
            OP_CPL: r.val = ~v & mask;
            default: r.val = v;  // NOP and reserved
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gp_reg_bank_cell.sv
// One WIDTH-bit register of the bank: bus write port plus in-place op port.
// A write in the same cycle as an op takes priority and suppresses the op.
module gp_reg_cell
    import comp_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             op_en,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             cvld
);

    op_res_t res;

    // Next value and carry strobe; carry is only valid when the op actually executes.
    always_comb begin
        res  = op_apply(op, MAX_W'(q), WIDTH);
        cout = res.c;
        cvld = op_en & ~we & res.cv;
    end

    // Register: write wins over op, otherwise hold.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)   q <= RESET_VAL;
        else if (we)    q <= wr_data;
        else if (op_en) q <= res.val[WIDTH-1:0];
    end

endmodule

// File: rtl/gp_reg_bank.sv
// General-purpose register bank: NUM_REGS cells, registered carry flag,
// combinational read mux with OE gating and a zero flag.
module gp_reg_bank
    import comp_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               NUM_REGS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SEL_W     = $clog2(NUM_REGS)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             WE,
    input  logic             load,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic             op_en,
    input  logic [2:0]       op,
    input  logic [SEL_W-1:0] op_sel,
    input  logic             OE,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] bus_out,
    output logic             zero,
    output logic             carry
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]            cout;
    logic [NUM_REGS-1:0]            cvld;
    logic                           wr_any;
    logic                           carry_upd;
    logic                           carry_nxt;
    logic [WIDTH-1:0]               rd_val;

    assign wr_any = WE | load;

    // Out-of-range selects match no cell, so writes and ops to them vanish.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        gp_reg_cell #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_cell (
            .CLK    (CLK),
            .RESET_N(RESET_N),
            .we     (wr_any && (wr_sel == SEL_W'(i))),
            .wr_data(bus_in),
            .op_en  (op_en && (op_sel == SEL_W'(i))),
            .op     (op),
            .q      (regs[i]),
            .cout   (cout[i]),
            .cvld   (cvld[i])
        );
    end

    // At most one cell strobes carry per cycle; pick it up.
    always_comb begin
        carry_upd = 1'b0;
        carry_nxt = carry;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cvld[i]) begin
                carry_upd = 1'b1;
                carry_nxt = cout[i];
            end
        end
    end

    // Carry flag register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)       carry <= 1'b0;
        else if (carry_upd) carry <= carry_nxt;
    end

    // Read mux; an unmatched select reads as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel == SEL_W'(i)) rd_val = regs[i];
        end
        bus_out = OE ? rd_val : '0;
        zero    = (rd_val == '0);
    end

endmodule

// File: tb/tb_gp_reg_bank.sv
// Directed self-checking bench for gp_reg_bank (8x4 default plus 12-bit x3).
module tb_gp_reg_bank;
    import comp_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // DUT A: WIDTH=8, NUM_REGS=4
    logic       rst_n;
    logic [7:0] bus_in;
    logic       we, ld, op_en, oe;
    logic [1:0] wr_sel, op_sel, rd_sel;
    logic [2:0] op;
    logic [7:0] bus_out;
    logic       zero, carry;

    gp_reg_bank #(.WIDTH(8), .NUM_REGS(4), .RESET_VAL(8'h00)) dut_a (
        .CLK(CLK), .RESET_N(rst_n), .bus_in(bus_in), .WE(we), .load(ld),
        .wr_sel(wr_sel), .op_en(op_en), .op(op), .op_sel(op_sel), .OE(oe),
        .rd_sel(rd_sel), .bus_out(bus_out), .zero(zero), .carry(carry)
    );

    // DUT B: WIDTH=12, NUM_REGS=3 (select value 3 is out of range)
    logic        b_rst_n;
    logic [11:0] b_bus_in;
    logic        b_we, b_ld, b_op_en, b_oe;
    logic [1:0]  b_wr_sel, b_op_sel, b_rd_sel;
    logic [2:0]  b_op;
    logic [11:0] b_bus_out;
    logic        b_zero, b_carry;

    gp_reg_bank #(.WIDTH(12), .NUM_REGS(3), .RESET_VAL(12'h000)) dut_b (
        .CLK(CLK), .RESET_N(b_rst_n), .bus_in(b_bus_in), .WE(b_we), .load(b_ld),
        .wr_sel(b_wr_sel), .op_en(b_op_en), .op(b_op), .op_sel(b_op_sel), .OE(b_oe),
        .rd_sel(b_rd_sel), .bus_out(b_bus_out), .zero(b_zero), .carry(b_carry)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [7:0] d);
        we = 1'b1; wr_sel = s; bus_in = d;
        tick();
        we = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] s, input logic [2:0] o);
        op_en = 1'b1; op_sel = s; op = o;
        tick();
        op_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; oe = 1'b1; rd_sel = 2'd0;
        #3;
        checks++; if (bus_out !== 8'h00) begin failures++; $display("FAIL reset_bus got=%h exp=00", bus_out); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry); end
        #1 rst_n = 1'b1;
        wr(2'd2, 8'hA5);
        rd_sel = 2'd2; #1;
        checks++; if (bus_out !== 8'hA5) begin failures++; $display("FAIL read_r2 got=%h exp=a5", bus_out); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL read_r2_zero got=%b exp=0", zero); end
        oe = 1'b0; #1;
        checks++; if (bus_out !== 8'h00) begin failures++; $display("FAIL oe_low got=%h exp=00", bus_out); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL oe_low_zero got=%b exp=0", zero); end
        oe = 1'b1;
    endtask

    task automatic test_arith();
        rd_sel = 2'd1;
        wr(2'd1, 8'hFF);
        do_op(2'd1, OP_INC);
        checks++; if (bus_out !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            failures++; $display("FAIL inc_wrap got=%h c=%b z=%b exp=00 c=1 z=1", bus_out, carry, zero); end
        do_op(2'd1, OP_DEC);
        checks++; if (bus_out !== 8'hFF || carry !== 1'b1) begin
            failures++; $display("FAIL dec_wrap got=%h c=%b exp=ff c=1", bus_out, carry); end
        wr(2'd1, 8'h10);
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL write_keeps_carry got=%b exp=1", carry); end
        do_op(2'd1, OP_DEC);
        checks++; if (bus_out !== 8'h0F || carry !== 1'b0) begin
            failures++; $display("FAIL dec_plain got=%h c=%b exp=0f c=0", bus_out, carry); end
    endtask

    task automatic test_shift();
        rd_sel = 2'd3;
        wr(2'd3, 8'h81);
        do_op(2'd3, OP_SHL);
        checks++; if (bus_out !== 8'h02 || carry !== 1'b1) begin
            failures++; $display("FAIL shl got=%h c=%b exp=02 c=1", bus_out, carry); end
        do_op(2'd3, OP_SHR);
        checks++; if (bus_out !== 8'h01 || carry !== 1'b0) begin
            failures++; $display("FAIL shr got=%h c=%b exp=01 c=0", bus_out, carry); end
        do_op(2'd3, OP_CPL);
        checks++; if (bus_out !== 8'hFE || carry !== 1'b0) begin
            failures++; $display("FAIL cpl got=%h c=%b exp=fe c=0", bus_out, carry); end
        do_op(2'd3, 3'b111);
        checks++; if (bus_out !== 8'hFE || carry !== 1'b0) begin
            failures++; $display("FAIL reserved got=%h c=%b exp=fe c=0", bus_out, carry); end
        do_op(2'd3, OP_SHR);  // carry <- 0 from LSB of FE, value 7F
        do_op(2'd3, OP_SHR);  // carry <- 1, value 3F
        do_op(2'd3, OP_CLR);
        checks++; if (bus_out !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            failures++; $display("FAIL clr got=%h c=%b z=%b exp=00 c=1 z=1", bus_out, carry, zero); end
    endtask

    // Collision cases driven through either WE or the legacy load alias.
    task automatic collide(input bit use_load);
        wr(2'd0, 8'h00);
        wr(2'd1, 8'hFF);
        do_op(2'd1, OP_INC);      // carry = 1, r1 = 00
        wr(2'd1, 8'h07);
        rd_sel = 2'd0;
        we = !use_load; ld = use_load; wr_sel = 2'd0; bus_in = 8'h33;
        op_en = 1'b1; op = OP_INC; op_sel = 2'd0;
        #1;
        checks++; if (bus_out !== 8'h00) begin failures++; $display("FAIL old_before_edge ld=%0d got=%h exp=00", use_load, bus_out); end
        tick();
        checks++; if (bus_out !== 8'h33 || carry !== 1'b1) begin
            failures++; $display("FAIL same_reg ld=%0d got=%h c=%b exp=33 c=1", use_load, bus_out, carry); end
        op_sel = 2'd1;
        tick();
        we = 1'b0; ld = 1'b0; op_en = 1'b0;
        checks++; if (bus_out !== 8'h33 || carry !== 1'b0) begin
            failures++; $display("FAIL diff_reg_r0 ld=%0d got=%h c=%b exp=33 c=0", use_load, bus_out, carry); end
        rd_sel = 2'd1; #1;
        checks++; if (bus_out !== 8'h08) begin failures++; $display("FAIL diff_reg_r1 ld=%0d got=%h exp=08", use_load, bus_out); end
    endtask

    task automatic test_collision();
        collide(1'b0);
        collide(1'b1);
    endtask

    task automatic test_async_reset();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h84};
        for (int i = 0; i < 4; i++) wr(2'(i), vals[i]);
        do_op(2'd3, OP_SHL);  // r3 = 08, carry = 1
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL pre_reset_carry got=%b exp=1", carry); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL async_carry got=%b exp=0", carry); end
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i); #1;
            checks++; if (bus_out !== 8'h00 || zero !== 1'b1) begin
                failures++; $display("FAIL async_r%0d got=%h z=%b exp=00 z=1", i, bus_out, zero); end
        end
        rst_n = 1'b1;
        rd_sel = 2'd0;
        wr(2'd0, 8'h5A);
        checks++; if (bus_out !== 8'h5A) begin failures++; $display("FAIL post_reset_write got=%h exp=5a", bus_out); end
    endtask

    task automatic test_nonpow2();
        b_oe = 1'b1;
        b_we = 1'b1; b_wr_sel = 2'd3; b_bus_in = 12'hABC; tick();
        b_wr_sel = 2'd2; b_bus_in = 12'hFFF; tick();
        b_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_rd_sel = 2'(i); #1;
            checks++;
            if (b_bus_out !== ((i == 2) ? 12'hFFF : 12'h000) || b_zero !== (i != 2)) begin
                failures++; $display("FAIL np2_read%0d got=%h z=%b", i, b_bus_out, b_zero); end
        end
        b_op_en = 1'b1; b_op_sel = 2'd2; b_op = OP_INC; tick();
        b_op_sel = 2'd3; b_op = OP_DEC; tick();  // out of range: no carry change
        b_op_en = 1'b0;
        b_rd_sel = 2'd2; #1;
        checks++; if (b_bus_out !== 12'h000 || b_carry !== 1'b1) begin
            failures++; $display("FAIL np2_inc12 got=%h c=%b exp=000 c=1", b_bus_out, b_carry); end
        b_we = 1'b1; b_wr_sel = 2'd1; b_bus_in = 12'h123; tick();
        b_we = 1'b0;
        #2 b_rst_n = 1'b0;
        b_rd_sel = 2'd1; #1;
        checks++; if (b_bus_out !== 12'h000 || b_carry !== 1'b0 || b_zero !== 1'b1) begin
            failures++; $display("FAIL np2_async got=%h c=%b z=%b exp=000 c=0 z=1", b_bus_out, b_carry, b_zero); end
        b_rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; bus_in = '0; we = 1'b0; ld = 1'b0; op_en = 1'b0; oe = 1'b0;
        wr_sel = '0; op_sel = '0; rd_sel = '0; op = OP_NOP;
        b_rst_n = 1'b0; b_bus_in = '0; b_we = 1'b0; b_ld = 1'b0; b_op_en = 1'b0; b_oe = 1'b0;
        b_wr_sel = '0; b_op_sel = '0; b_rd_sel = '0; b_op = OP_NOP;
        test_reset();
        b_rst_n = 1'b1;
        test_arith();
        test_shift();
        test_collision();
        test_async_reset();
        test_nonpow2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
